// File: rtl/lt24_pkg.sv
// Shared constants and types for the LT24 panel-side bus sink.
// Optional statistics outputs are enabled with LT24_SINK_STATS_EN.
package lt24_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CASET = 3'd1,
        PASET = 3'd2,
        RAMWR = 3'd3,
        SKIP  = 3'd4
    } state_e;

    typedef logic [8:0] coord_t;

endpackage

// File: rtl/lt24_bus_sink_if.sv
// 8080-style LT24 write bus as driven by the controller (master) and seen by the panel (slave).
interface lt24_bus_sink_if;

    logic        csx;
    logic        dcx;
    logic        wrx;
    logic        rdx;
    logic        lcd_reset_n;
    logic [15:0] data_in;

    modport master (output csx, dcx, wrx, rdx, lcd_reset_n, data_in);
    modport slave  (input  csx, dcx, wrx, rdx, lcd_reset_n, data_in);

endinterface

// File: rtl/lt24_bus_sync.sv
// Bus input synchronizer with wrx rising-edge strobe and read-attempt detection.
// All outputs leave through the same two register stages so they stay aligned.
module lt24_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csx_i,
    input  logic        dcx_i,
    input  logic        wrx_i,
    input  logic        rdx_i,
    input  logic        lcd_reset_n_i,
    input  logic [15:0] data_i,
    output logic        strobe_o,
    output logic        dcx_o,
    output logic        rd_o,
    output logic        lcd_reset_n_o,
    output logic [15:0] data_o
);

    // {lcd_reset_n, rdx, csx, dcx, wrx, data}
    localparam logic [20:0] BUS_IDLE = {5'b11101, 16'h0000};
    // {strobe, dcx, rd, lcd_reset_n, data}
    localparam logic [19:0] ALN_RST  = {4'b0001, 16'h0000};

    logic [20:0] sync_q [SYNC_STAGES];
    logic [17:0] prev_q;
    logic [20:0] cur;
    logic [19:0] aln_d, aln1_q, aln2_q;

    assign cur = sync_q[SYNC_STAGES-1];

    // dcx/data come from the last sample with wrx still low, so a bus change
    // right after the wrx rise can never be captured instead.
    assign aln_d = {cur[16] & ~prev_q[16] & ~cur[18],
                    prev_q[17],
                    ~cur[19] & ~cur[18],
                    cur[20],
                    prev_q[15:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= BUS_IDLE;
            prev_q <= BUS_IDLE[17:0];
            aln1_q <= ALN_RST;
            aln2_q <= ALN_RST;
        end else begin
            sync_q[0] <= {lcd_reset_n_i, rdx_i, csx_i, dcx_i, wrx_i, data_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= cur[17:0];
            aln1_q <= aln_d;
            aln2_q <= aln1_q;
        end
    end

    assign {strobe_o, dcx_o, rd_o, lcd_reset_n_o, data_o} = aln2_q;

endmodule

// File: rtl/lt24_bus_sink.sv
// ILI9341-style decoder for LT24 bus writes: commands, CASET/PASET windows, RAMWR pixels with (x,y).
// Define LT24_SINK_STATS_EN to add the frame_done and pix_count outputs.
//
// state | meaning
// IDLE  | no active command; parameters ignored
// CASET | collecting 4 column-window parameter bytes
// PASET | collecting 4 page-window parameter bytes
// RAMWR | each data write is a pixel at (x,y)
// SKIP  | unsupported command; parameters ignored
module lt24_bus_sink
    import lt24_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int H_RES       = 240,
    parameter int V_RES       = 320
) (
    input  logic          clk,
    input  logic          reset_n,
    lt24_bus_sink_if.slave bus,
    output logic          cmd_valid,
    output logic [7:0]    cmd_code,
    output logic          pix_valid,
    output logic [8:0]    pix_x,
    output logic [8:0]    pix_y,
    output logic [15:0]   pix_data,
    output logic          protocol_error
`ifdef LT24_SINK_STATS_EN
    ,
    output logic          frame_done,
    output logic [31:0]   pix_count
`endif
);

    localparam coord_t      EC_DEF = coord_t'(H_RES - 1);
    localparam coord_t      EP_DEF = coord_t'(V_RES - 1);
    localparam logic [15:0] H_LIM  = 16'(H_RES);
    localparam logic [15:0] V_LIM  = 16'(V_RES);

    logic        strobe, s_dcx, s_rd, s_lcd_rst_n;
    logic [15:0] s_data;

    lt24_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk           (clk),
        .reset_n       (reset_n),
        .csx_i         (bus.csx),
        .dcx_i         (bus.dcx),
        .wrx_i         (bus.wrx),
        .rdx_i         (bus.rdx),
        .lcd_reset_n_i (bus.lcd_reset_n),
        .data_i        (bus.data_in),
        .strobe_o      (strobe),
        .dcx_o         (s_dcx),
        .rd_o          (s_rd),
        .lcd_reset_n_o (s_lcd_rst_n),
        .data_o        (s_data)
    );

    state_e      state_q, state_d;
    logic [1:0]  pidx_q, pidx_d;
    logic [15:0] sh_start_q, sh_start_d;
    logic [7:0]  sh_end_hi_q, sh_end_hi_d;
    coord_t      sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    coord_t      x_q, x_d, y_q, y_d;
    logic        cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d, err_q, err_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    coord_t      pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic [15:0] win_end;
    logic        win_bad;
`ifdef LT24_SINK_STATS_EN
    logic        frame_done_q, frame_done_d;
    logic [31:0] pix_count_q, pix_count_d;
`endif

    always_comb begin
        state_d     = state_q;
        pidx_d      = pidx_q;
        sh_start_d  = sh_start_q;
        sh_end_hi_d = sh_end_hi_q;
        sc_d        = sc_q;
        ec_d        = ec_q;
        sp_d        = sp_q;
        ep_d        = ep_q;
        x_d         = x_q;
        y_d         = y_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_data_d  = pix_data_q;
        err_d       = err_q | s_rd;
`ifdef LT24_SINK_STATS_EN
        frame_done_d = 1'b0;
        pix_count_d  = pix_count_q;
`endif
        win_end = {sh_end_hi_q, s_data[7:0]};
        win_bad = (sh_start_q > win_end) ||
                  (win_end >= ((state_q == CASET) ? H_LIM : V_LIM));

        if (strobe) begin
            if (!s_dcx) begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = s_data[7:0];
                pidx_d      = 2'd0;
                case (s_data[7:0])
                    CMD_CASET: state_d = CASET;
                    CMD_PASET: state_d = PASET;
                    CMD_RAMWR: begin
                        state_d = RAMWR;
                        x_d     = sc_q;
                        y_d     = sp_q;
`ifdef LT24_SINK_STATS_EN
                        pix_count_d = '0;
`endif
                    end
                    CMD_SWRESET: begin
                        state_d = IDLE;
                        sc_d    = '0;
                        ec_d    = EC_DEF;
                        sp_d    = '0;
                        ep_d    = EP_DEF;
                    end
                    default: state_d = SKIP;
                endcase
            end else begin
                case (state_q)
                    CASET, PASET: begin
                        pidx_d = pidx_q + 2'd1;
                        case (pidx_q)
                            2'd0: sh_start_d[15:8] = s_data[7:0];
                            2'd1: sh_start_d[7:0]  = s_data[7:0];
                            2'd2: sh_end_hi_d      = s_data[7:0];
                            default: begin
                                state_d = IDLE;
                                if (win_bad) begin
                                    err_d = 1'b1;
                                end else if (state_q == CASET) begin
                                    sc_d = sh_start_q[8:0];
                                    ec_d = win_end[8:0];
                                end else begin
                                    sp_d = sh_start_q[8:0];
                                    ep_d = win_end[8:0];
                                end
                            end
                        endcase
                    end
                    RAMWR: begin
                        pix_valid_d = 1'b1;
                        pix_x_d     = x_q;
                        pix_y_d     = y_q;
                        pix_data_d  = s_data;
                        if (x_q == ec_q) begin
                            x_d = sc_q;
                            y_d = (y_q == ep_q) ? sp_q : y_q + 9'd1;
                        end else begin
                            x_d = x_q + 9'd1;
                        end
`ifdef LT24_SINK_STATS_EN
                        frame_done_d = (x_q == ec_q) && (y_q == ep_q);
                        if (pix_count_q != 32'hFFFF_FFFF) pix_count_d = pix_count_q + 32'd1;
`endif
                    end
                    default: ;
                endcase
            end
        end

        // Panel hardware reset behaves like reset_n but leaves the synchronizers running.
        if (!s_lcd_rst_n) begin
            state_d     = IDLE;
            pidx_d      = '0;
            sh_start_d  = '0;
            sh_end_hi_d = '0;
            sc_d        = '0;
            ec_d        = EC_DEF;
            sp_d        = '0;
            ep_d        = EP_DEF;
            x_d         = '0;
            y_d         = '0;
            cmd_valid_d = 1'b0;
            cmd_code_d  = '0;
            pix_valid_d = 1'b0;
            pix_x_d     = '0;
            pix_y_d     = '0;
            pix_data_d  = '0;
            err_d       = 1'b0;
`ifdef LT24_SINK_STATS_EN
            frame_done_d = 1'b0;
            pix_count_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pidx_q      <= '0;
            sh_start_q  <= '0;
            sh_end_hi_q <= '0;
            sc_q        <= '0;
            ec_q        <= EC_DEF;
            sp_q        <= '0;
            ep_q        <= EP_DEF;
            x_q         <= '0;
            y_q         <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_data_q  <= '0;
            err_q       <= 1'b0;
`ifdef LT24_SINK_STATS_EN
            frame_done_q <= 1'b0;
            pix_count_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pidx_q      <= pidx_d;
            sh_start_q  <= sh_start_d;
            sh_end_hi_q <= sh_end_hi_d;
            sc_q        <= sc_d;
            ec_q        <= ec_d;
            sp_q        <= sp_d;
            ep_q        <= ep_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_data_q  <= pix_data_d;
            err_q       <= err_d;
`ifdef LT24_SINK_STATS_EN
            frame_done_q <= frame_done_d;
            pix_count_q  <= pix_count_d;
`endif
        end
    end

    assign cmd_valid      = cmd_valid_q;
    assign cmd_code       = cmd_code_q;
    assign pix_valid      = pix_valid_q;
    assign pix_x          = pix_x_q;
    assign pix_y          = pix_y_q;
    assign pix_data       = pix_data_q;
    assign protocol_error = err_q;
`ifdef LT24_SINK_STATS_EN
    assign frame_done     = frame_done_q;
    assign pix_count      = pix_count_q;
`endif

endmodule

// File: doc/lt24_bus_sink.md
Name: lt24_bus_sink

Overview:
- Panel-side responder for the LT24 8080-style write bus (csx/dcx/wrx/rdx/16-bit data) that our LT24 controller drives.
- Decodes command/parameter/pixel writes the way the ILI9341 does and emits pixel writes with (x,y) coordinates.
- Used as a synthesizable panel emulator: on-board loopback, frame capture and protocol checking of the controller without the physical LCD.
- Sits between the controller's LCD pins and a capture memory or checker.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on every bus input (min 2).
- H_RES, 240, panel columns; default column window is 0..H_RES-1.
- V_RES, 320, panel rows; default page window is 0..V_RES-1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- lcd_reset_n  in  1  panel hardware reset from the controller, active low; asynchronous to clk.
- csx  in  1  chip select, active low.
- dcx  in  1  0 = command, 1 = parameter/pixel data.
- wrx  in  1  write strobe; data is taken on the rising edge.
- rdx  in  1  read strobe, active low; reads are not supported.
- data_in  in  16  bus data.
- cmd_valid  out  1  one-cycle pulse per decoded command byte.
- cmd_code  out  8  last command byte.
- pix_valid  out  1  one-cycle pulse per pixel write.
- pix_x  out  9  pixel column.
- pix_y  out  9  pixel row.
- pix_data  out  16  RGB565 pixel value.
- protocol_error  out  1  sticky error flag; cleared only by reset_n or a synchronized lcd_reset_n low.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all outputs 0; FSM in IDLE.
  - windows SC=0, EC=H_RES-1, SP=0, EP=V_RES-1; x/y counters 0.
- Input conditioning:
  - csx, dcx, wrx, rdx, lcd_reset_n and data_in each pass through SYNC_STAGES flops, so they stay aligned.
  - A write strobe is a synchronized wrx 0->1 transition while synchronized csx=0.
  - Host timing: wrx low and wrx high each last at least SYNC_STAGES+1 clk periods; data_in stays stable from wrx fall to wrx rise.
- Latency: pix_valid or cmd_valid asserts exactly SYNC_STAGES+2 clk after the first clk edge that samples wrx high.
- Command write (dcx=0):
  - Pulse cmd_valid; cmd_code = data_in[7:0].
  - Any command aborts the current state and enters the new one.
  - 0x2A -> CASET, param index = 0.
  - 0x2B -> PASET, param index = 0.
  - 0x2C -> RAMWR; load x=SC, y=SP.
  - 0x01 -> restore default windows, go to IDLE.
  - Any other code -> SKIP (parameters ignored).
- CASET / PASET parameters:
  - Four parameter bytes, using data_in[7:0]: start[15:8], start[7:0], end[15:8], end[7:0].
  - Staged in shadow registers and committed after the 4th byte, then go to IDLE.
  - Reject and set protocol_error (window unchanged) if start>end, or end>=H_RES for CASET, or end>=V_RES for PASET.
  - A 5th or later parameter is ignored.
- RAMWR data (dcx=1):
  - Pulse pix_valid with pix_x=x, pix_y=y, pix_data=data_in.
  - Advance: if x==EC then x=SC and y increments; if y==EP at that moment, y wraps to SP; otherwise x increments.
  - Remains in RAMWR until the next command.
- Parameter writes in IDLE or SKIP: no output, no error.
- csx high: masks strobes only; FSM state and counters are held.
- A csx fall/rise mid-burst followed by further data continues at the current x,y.
- Read attempt (synchronized rdx=0 with csx=0): set protocol_error; nothing else changes.
- Synchronized wrx=0 and rdx=0 together with csx=0: set protocol_error, and the strobe is still processed.
- Synchronized lcd_reset_n=0 has the same effect as reset_n, applied synchronously and held while low; the input synchronizers are not cleared.

Optional Feature:
- Macro: LT24_SINK_STATS_EN.
- When defined, adds:
  - frame_done out 1: pulses in the same cycle as the pix_valid that writes (EC,EP).
  - pix_count out 32: counts pix_valid pulses; clears on reset, lcd_reset_n or the 0x2C command; saturates at 0xFFFFFFFF.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package lt24_pkg:
  - command constants CMD_SWRESET=0x01, CMD_CASET=0x2A, CMD_PASET=0x2B, CMD_RAMWR=0x2C.
  - FSM state enum {IDLE, CASET, PASET, RAMWR, SKIP}.
  - 9-bit coordinate typedef.
- Sub-module lt24_bus_sync: parameterized synchronizer plus wrx rising-edge and rd detection; outputs aligned strobe, dcx, data and an rd flag.

Test Plan:
- Reset: release reset_n, send cmd 0x2C then data 0xF800 -> pix_valid once, x=0, y=0, pix_data=0xF800, latency SYNC_STAGES+2.
- Window: CASET 0,10,0,12; PASET 0,20,0,21; RAMWR; 6 pixels -> (10,20),(11,20),(12,20),(10,21),(11,21),(12,21).
- Wrap: same window, a 7th pixel -> (10,20); frame_done pulses on the 6th pixel when LT24_SINK_STATS_EN is defined.
- Bad window: CASET 0,50,0,10 -> protocol_error=1; a following RAMWR starts at the previous SC.
- Abort and mask: RAMWR, 2 pixels, csx high for 20 cycles, 1 pixel -> continues at x=2; then cmd 0x2A, 2 params, cmd 0x2C -> CASET not committed.
- Read and reset: rdx low with csx low -> protocol_error=1; pulse lcd_reset_n low -> error cleared, windows back to 0..239/0..319.
